// File: rtl/countdown_timer_if.sv
// Handshake bundle for countdown_timer: load/enable controls from the sequencer,
// counter state and status flags back from the timer.
interface countdown_timer_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output load, load_value, enable,
    input  count, busy, done, zero
  );

  modport slave (
    input  load, load_value, enable,
    output count, busy, done, zero
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/DONE control FSM and a one-cycle done pulse.
// Optional periodic reload is enabled by defining COUNTDOWN_TIMER_AUTORELOAD_EN.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] next_count_s;
  logic [WIDTH-1:0] dec_s;
  logic             busy_r;
  logic             done_r;
  logic             zero_r;

  // Decrement reuses the adder form: count plus all-ones, carry-in zero, truncated.
  assign dec_s = count_r + ALL_ONES;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_r;

  // Reload value follows every accepted load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload_r <= ZERO_VAL;
    end else if (bus.load) begin
      reload_r <= bus.load_value;
    end else begin
      reload_r <= reload_r;
    end
  end
`endif

  // Next-state and next-count decode; load always wins over enable.
  always_comb begin
    next_state_s = state_r;
    next_count_s = count_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.load) begin
          next_count_s = bus.load_value;
          next_state_s = (bus.load_value != ZERO_VAL) ? ST_RUN : ST_DONE;
        end else begin
          next_count_s = count_r;
        end
      end
      ST_RUN: begin
        if (bus.load) begin
          next_count_s = bus.load_value;
          next_state_s = (bus.load_value != ZERO_VAL) ? ST_RUN : ST_DONE;
        end else if (bus.enable) begin
          next_count_s = dec_s;
          next_state_s = (count_r == ONE_VAL) ? ST_DONE : ST_RUN;
        end else begin
          next_count_s = count_r;
        end
      end
      ST_DONE: begin
        if (bus.load) begin
          next_count_s = bus.load_value;
          next_state_s = (bus.load_value != ZERO_VAL) ? ST_RUN : ST_DONE;
        end else begin
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
          if (reload_r != ZERO_VAL) begin
            next_count_s = reload_r;
            next_state_s = ST_RUN;
          end else begin
            next_count_s = ZERO_VAL;
            next_state_s = ST_IDLE;
          end
`else
          next_count_s = ZERO_VAL;
          next_state_s = ST_IDLE;
`endif
        end
      end
      default: begin
        next_count_s = ZERO_VAL;
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, counter and status flags are all registered from the next-state decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      count_r <= ZERO_VAL;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      zero_r  <= 1'b1;
    end else begin
      state_r <= next_state_s;
      count_r <= next_count_s;
      busy_r  <= (next_state_s == ST_RUN);
      done_r  <= (next_state_s == ST_DONE);
      zero_r  <= (next_count_s == ZERO_VAL);
    end
  end

  assign bus.count = count_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.zero  = zero_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (WIDTH=8); expectations follow
// COUNTDOWN_TIMER_AUTORELOAD_EN when the bench is built with it defined.
module tb_countdown_timer;

  localparam int WIDTH = 8;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   busy_cycles;

  countdown_timer_if #(.WIDTH(WIDTH)) bus_if ();

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] c, input logic [31:0] b,
                           input logic [31:0] d, input logic [31:0] z);
    check_val({tag, ".count"}, 32'(bus_if.count), c);
    check_val({tag, ".busy"},  32'(bus_if.busy),  b);
    check_val({tag, ".done"},  32'(bus_if.done),  d);
    check_val({tag, ".zero"},  32'(bus_if.zero),  z);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    bus_if.load = 1'b0;
    bus_if.load_value = 8'd0;
    bus_if.enable = 1'b0;
    #12;
    check_all("reset", 32'd0, 32'd0, 32'd0, 32'd1);
    reset_n = 1'b1;

    // Basic countdown: load 3, enable high
    step();
    bus_if.load = 1'b1; bus_if.load_value = 8'd3; bus_if.enable = 1'b1;
    step();
    check_all("basic_ld", 32'd3, 32'd1, 32'd0, 32'd0);
    bus_if.load = 1'b0;
    step(); check_val("basic_c2", 32'(bus_if.count), 32'd2);
    step(); check_all("basic_c1", 32'd1, 32'd1, 32'd0, 32'd0);
    step(); check_all("basic_done", 32'd0, 32'd0, 32'd1, 32'd1);
    bus_if.enable = 1'b0;
    step();
    check_all("basic_after", AR ? 32'd3 : 32'd0, AR ? 32'd1 : 32'd0, 32'd0, AR ? 32'd0 : 32'd1);

    // Gated enable: load 2, enable 1,0,0,1
    bus_if.load = 1'b1; bus_if.load_value = 8'd2;
    step(); check_all("gate_ld", 32'd2, 32'd1, 32'd0, 32'd0);
    bus_if.load = 1'b0; bus_if.enable = 1'b1;
    step(); check_val("gate_e1", 32'(bus_if.count), 32'd1);
    bus_if.enable = 1'b0;
    step(); check_all("gate_e0a", 32'd1, 32'd1, 32'd0, 32'd0);
    step(); check_all("gate_e0b", 32'd1, 32'd1, 32'd0, 32'd0);
    bus_if.enable = 1'b1;
    step(); check_all("gate_done", 32'd0, 32'd0, 32'd1, 32'd1);
    bus_if.enable = 1'b0;
    step(); check_val("gate_after.done", 32'(bus_if.done), 32'd0);

    // Zero load: done next cycle, busy never rises
    bus_if.load = 1'b1; bus_if.load_value = 8'd0;
    step(); check_all("zero_ld", 32'd0, 32'd0, 32'd1, 32'd1);
    bus_if.load = 1'b0;
    step(); check_all("zero_after", 32'd0, 32'd0, 32'd0, 32'd1);

    // Enable in IDLE at zero: no wrap
    bus_if.enable = 1'b1;
    step(); step();
    check_all("idle_en", 32'd0, 32'd0, 32'd0, 32'd1);

    // Limit load 8'hFF with enable high: 255 busy cycles then done
    bus_if.load = 1'b1; bus_if.load_value = 8'hFF;
    step(); check_all("ff_ld", 32'd255, 32'd1, 32'd0, 32'd0);
    bus_if.load = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus_if.done) break;
      if (bus_if.busy) busy_cycles++;
      step();
    end
    check_val("ff_done", 32'(bus_if.done), 32'd1);
    check_val("ff_busy_cycles", 32'(busy_cycles), 32'd255);
    step(); check_val("ff_after.done", 32'(bus_if.done), 32'd0);

    // Load priority over enable in RUN
    bus_if.load = 1'b1; bus_if.load_value = 8'd6;
    step(); bus_if.load = 1'b0;
    step(); step();
    check_val("prio_c4", 32'(bus_if.count), 32'd4);
    bus_if.load = 1'b1; bus_if.load_value = 8'd7;
    step(); check_all("prio_ld", 32'd7, 32'd1, 32'd0, 32'd0);

    // Load accepted during DONE
    bus_if.load_value = 8'd1;
    step(); bus_if.load = 1'b0;
    step(); check_all("dld_done", 32'd0, 32'd0, 32'd1, 32'd1);
    bus_if.load = 1'b1; bus_if.load_value = 8'd5;
    step(); check_all("dld_ld", 32'd5, 32'd1, 32'd0, 32'd0);

    // Back-to-back zero loads give consecutive done pulses
    bus_if.load_value = 8'd0;
    step(); check_val("b2b_d1", 32'(bus_if.done), 32'd1);
    step(); check_val("b2b_d2", 32'(bus_if.done), 32'd1);
    bus_if.load = 1'b0;
    step(); check_val("b2b_d3", 32'(bus_if.done), 32'd0);

    // Asynchronous reset mid-RUN at count 5
    bus_if.enable = 1'b0;
    bus_if.load = 1'b1; bus_if.load_value = 8'd5;
    step(); bus_if.load = 1'b0;
    check_all("rst_pre", 32'd5, 32'd1, 32'd0, 32'd0);
    #3 reset_n = 1'b0;
    #1 check_all("rst_async", 32'd0, 32'd0, 32'd0, 32'd1);
    #2 reset_n = 1'b1;

    // Autoreload period (single pulse when the feature is absent)
    bus_if.enable = 1'b1;
    bus_if.load = 1'b1; bus_if.load_value = 8'd2;
    step(); bus_if.load = 1'b0;
    check_val("ar_c2", 32'(bus_if.count), 32'd2);
    step(); check_val("ar_c1", 32'(bus_if.count), 32'd1);
    step(); check_all("ar_done1", 32'd0, 32'd0, 32'd1, 32'd1);
    step(); check_all("ar_next", AR ? 32'd2 : 32'd0, AR ? 32'd1 : 32'd0, 32'd0, AR ? 32'd0 : 32'd1);
    step();
    step(); check_val("ar_done2", 32'(bus_if.done), AR ? 32'd1 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
